// File: rtl/onp_result_formatter.sv
// Signed ALU result to decimal ASCII byte stream, one power-of-ten subtraction per cycle.
// Optional trailing CR/LF is enabled by defining FMT_CRLF_EN.
module onp_result_formatter #(
    parameter int DATA_W     = 32,
    parameter int MAX_DIGITS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_result,
    input  logic              i_result_ready,
    output logic [7:0]        o_char,
    output logic              o_char_valid,
    input  logic              i_char_ready,
    output logic              o_busy,
    output logic              o_dropped
);

    localparam int IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SIGN  = 3'd1,
        S_DIGIT = 3'd2,
        S_EMIT  = 3'd3
`ifdef FMT_CRLF_EN
        ,
        S_CR    = 3'd4,
        S_LF    = 3'd5
`endif
    } state_t;

    // Elaboration-time power of ten, width-limited to DATA_W.
    function automatic logic [DATA_W-1:0] pow10_f(input int k);
        logic [DATA_W-1:0] p;
        p = DATA_W'(1);
        for (int i = 0; i < k; i++) begin
            p = p * DATA_W'(10);
        end
        return p;
    endfunction

    logic [DATA_W-1:0] pow10_rom [MAX_DIGITS];

    generate
        for (genvar g = 0; g < MAX_DIGITS; g++) begin : g_rom
            assign pow10_rom[g] = pow10_f(g);
        end
    endgenerate

    state_t            state;
    logic [DATA_W-1:0] mag;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        cnt;
    logic              lead;

    logic              neg;
    logic [DATA_W-1:0] abs_val;
    logic [DATA_W-1:0] cur_pow;

    // Magnitude as unsigned so the most negative input maps to 2^(DATA_W-1).
    always_comb begin
        neg     = i_result[DATA_W-1];
        abs_val = i_result;
        if (neg) begin
            abs_val = ~i_result + DATA_W'(1);
        end else begin
            abs_val = i_result;
        end
    end

    // Power-of-ten lookup for the current digit position.
    always_comb begin
        cur_pow = '0;
        if (32'(idx) < MAX_DIGITS) begin
            cur_pow = pow10_rom[idx];
        end else begin
            cur_pow = '0;
        end
    end

    // Conversion FSM with registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            mag          <= '0;
            idx          <= '0;
            cnt          <= 4'd0;
            lead         <= 1'b0;
            o_char       <= 8'h00;
            o_char_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_dropped    <= 1'b0;
        end else begin
            o_dropped <= (state != S_IDLE) && i_result_ready;
            case (state)
                S_IDLE: begin
                    if (i_result_ready) begin
                        mag    <= abs_val;
                        idx    <= IDX_LAST;
                        cnt    <= 4'd0;
                        lead   <= 1'b1;
                        o_busy <= 1'b1;
                        if (neg) begin
                            o_char       <= 8'h2D;
                            o_char_valid <= 1'b1;
                            state        <= S_SIGN;
                        end else begin
                            state <= S_DIGIT;
                        end
                    end
                end
                S_SIGN: begin
                    if (i_char_ready) begin
                        o_char_valid <= 1'b0;
                        o_char       <= 8'h00;
                        state        <= S_DIGIT;
                    end
                end
                S_DIGIT: begin
                    if (mag >= cur_pow) begin
                        mag <= mag - cur_pow;
                        cnt <= cnt + 4'd1;
                    end else if (lead && (cnt == 4'd0) && (idx != '0)) begin
                        idx <= idx - IDX_W'(1);
                        cnt <= 4'd0;
                    end else begin
                        o_char       <= 8'h30 + {4'd0, cnt};
                        o_char_valid <= 1'b1;
                        lead         <= 1'b0;
                        state        <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (i_char_ready) begin
                        if (idx == '0) begin
`ifdef FMT_CRLF_EN
                            o_char <= 8'h0D;
                            state  <= S_CR;
`else
                            o_char_valid <= 1'b0;
                            o_char       <= 8'h00;
                            o_busy       <= 1'b0;
                            state        <= S_IDLE;
`endif
                        end else begin
                            o_char_valid <= 1'b0;
                            o_char       <= 8'h00;
                            idx          <= idx - IDX_W'(1);
                            cnt          <= 4'd0;
                            state        <= S_DIGIT;
                        end
                    end
                end
`ifdef FMT_CRLF_EN
                S_CR: begin
                    if (i_char_ready) begin
                        o_char <= 8'h0A;
                        state  <= S_LF;
                    end
                end
                S_LF: begin
                    if (i_char_ready) begin
                        o_char_valid <= 1'b0;
                        o_char       <= 8'h00;
                        o_busy       <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
`endif
                default: begin
                    o_char_valid <= 1'b0;
                    o_char       <= 8'h00;
                    o_busy       <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onp_result_formatter.sv
// Bench for onp_result_formatter: directed and random values against a decimal-string model.
module tb_onp_result_formatter;

    localparam int MAXD = 10;

    logic        clk;
    logic        rst;
    logic [31:0] i_result;
    logic        i_result_ready;
    logic [7:0]  o_char;
    logic        o_char_valid;
    logic        i_char_ready;
    logic        o_busy;
    logic        o_dropped;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    int         exp_lz;
    int         exp_fd;

    onp_result_formatter #(.DATA_W(32), .MAX_DIGITS(MAXD)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_result       (i_result),
        .i_result_ready (i_result_ready),
        .o_char         (o_char),
        .o_char_valid   (o_char_valid),
        .i_char_ready   (i_char_ready),
        .o_busy         (o_busy),
        .o_dropped      (o_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected text from ordinary decimal arithmetic on the signed value.
    task automatic model(input logic [31:0] v);
        longint     m;
        logic [7:0] d[$];
        exp_q.delete();
        m = longint'($signed(v));
        if (m < 0) begin
            exp_q.push_back(8'h2D);
            m = -m;
        end
        do begin
            d.push_front(8'h30 + 8'(m % 10));
            m = m / 10;
        end while (m > 0);
        exp_lz = MAXD - d.size();
        exp_fd = int'(d[0]) - 48;
        foreach (d[k]) exp_q.push_back(d[k]);
`ifdef FMT_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    // Call at a falling edge; returns at the falling edge after the last transfer.
    task automatic convert(input logic [31:0] v, input int hold_mode, input int drop_at);
        int t, held, cur_hold, first_seen;
        bit pending, drop_prev;
        model(v);
        i_result       = v;
        i_result_ready = 1'b1;
        @(negedge clk);
        i_result_ready = 1'b0;
        chk("busy_after_capture", {31'd0, o_busy}, 32'd1);
        if (v[31]) begin
            chk("sign_latency_valid", {31'd0, o_char_valid}, 32'd1);
            chk("sign_latency_char", {24'd0, o_char}, 32'h2D);
        end
        t = 0; held = 0; pending = 1'b0; drop_prev = 1'b0; first_seen = -1;
        cur_hold = (hold_mode < 0) ? int'($urandom_range(3, 0)) : hold_mode;
        while (exp_q.size() > 0 && t < 4000) begin
            chk("dropped", {31'd0, o_dropped}, {31'd0, drop_prev});
            if (pending) chk("valid_held", {31'd0, o_char_valid}, 32'd1);
            i_char_ready = 1'b0;
            pending      = 1'b0;
            if (o_char_valid) begin
                if (first_seen < 0) first_seen = t;
                chk("char", {24'd0, o_char}, {24'd0, exp_q[0]});
                if (held >= cur_hold) begin
                    i_char_ready = 1'b1;
                    void'(exp_q.pop_front());
                    held     = 0;
                    cur_hold = (hold_mode < 0) ? int'($urandom_range(3, 0)) : hold_mode;
                end else begin
                    held++;
                    pending = 1'b1;
                end
            end
            if (t == drop_at) begin
                i_result       = $urandom;
                i_result_ready = 1'b1;
                drop_prev      = 1'b1;
            end else begin
                i_result_ready = 1'b0;
                drop_prev      = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        i_char_ready   = 1'b0;
        i_result_ready = 1'b0;
        chk("bytes_left_timeout", exp_q.size(), 32'd0);
        chk("busy_after_last", {31'd0, o_busy}, 32'd0);
        chk("valid_after_last", {31'd0, o_char_valid}, 32'd0);
        chk("dropped_end", {31'd0, o_dropped}, {31'd0, drop_prev});
        if (!v[31]) begin
            chk("first_digit_latency",
                {31'd0, (first_seen >= 0) && (first_seen <= exp_lz + exp_fd + 1)}, 32'd1);
        end
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_valid", {31'd0, o_char_valid}, 32'd0);
            chk("idle_busy", {31'd0, o_busy}, 32'd0);
        end
    endtask

    initial begin
        int r;
        rst            = 1'b1;
        i_result       = 32'd0;
        i_result_ready = 1'b0;
        i_char_ready   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_char", {24'd0, o_char}, 32'd0);
        chk("rst_valid", {31'd0, o_char_valid}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_dropped", {31'd0, o_dropped}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        convert(32'd0, 0, -1);
        idle_check(3);
        convert(32'd123, 0, -1);
        idle_check(1);
        convert(-32'sd45, 0, -1);
        idle_check(1);
        convert(32'h8000_0000, 0, -1);
        convert(32'h7FFF_FFFF, 0, -1);
        idle_check(1);
        convert(32'd907, 5, -1);
        idle_check(1);
        convert(32'd123, 0, 4);
        idle_check(1);
        convert(-32'sd2000000000, 1, 8);
        idle_check(1);

        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                r = int'($urandom_range(1000, 0)) - 500;
                convert(32'(r), -1, -1);
            end else begin
                convert($urandom, -1, -1);
            end
        end
        idle_check(1);

        i_result       = 32'h8000_0000;
        i_result_ready = 1'b1;
        i_char_ready   = 1'b1;
        @(negedge clk);
        i_result_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_rst", {31'd0, o_busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_char", {24'd0, o_char}, 32'd0);
        chk("midrst_valid", {31'd0, o_char_valid}, 32'd0);
        chk("midrst_busy", {31'd0, o_busy}, 32'd0);
        chk("midrst_dropped", {31'd0, o_dropped}, 32'd0);
        @(negedge clk);
        rst          = 1'b0;
        i_char_ready = 1'b0;
        @(negedge clk);
        convert(32'd907, 2, -1);
        idle_check(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
